obstacle_collision_checker: RTL and testbench

- Reads the active map's 12 obstacle rectangles and answers "does this sprite box collide with anything?" for tank/bullet movement logic.
- Sequential scan: one obstacle per clock, started by a request pulse, finished by a one-cycle done pulse.
- Sits between the obstacle map generator (rectangle source) and the game/motion controllers (query sources).

---
 rtl/obstacle_collision_checker.sv | 117 +++++++++++
 tb/tb_obstacle_collision_checker.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_collision_checker.sv
// Sequential sprite-vs-obstacle collision checker: screen-bounds test, then one obstacle per clock.
// Optional COLLISION_EARLY_EXIT_EN ends the scan on the first overlapping obstacle.
module obstacle_collision_checker #(
    parameter int NUM_OBS = 12,
    parameter int SCR_W   = 640,
    parameter int SCR_H   = 480
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    req,
    input  logic [9:0]              qx,
    input  logic [8:0]              qy,
    input  logic [5:0]              qw,
    input  logic [5:0]              qh,
    input  logic [NUM_OBS-1:0][9:0] obs_left,
    input  logic [NUM_OBS-1:0][9:0] obs_right,
    input  logic [NUM_OBS-1:0][8:0] obs_top,
    input  logic [NUM_OBS-1:0][8:0] obs_bottom,
    output logic                    busy,
    output logic                    done,
    output logic                    hit,
    output logic [3:0]              hit_index
);

    typedef enum logic [1:0] {IDLE, BOUNDS, SCAN, DONE} state_t;

    state_t      state, state_nx;
    logic [9:0]  lx;
    logic [8:0]  ly;
    logic [5:0]  lw, lh;
    logic [3:0]  idx;
    logic        hit_f;
    logic [3:0]  hit_idx_f;
    logic [10:0] x_end;
    logic [9:0]  y_end;
    logic        wall, ov, last;

    // Ends are computed one bit wider than the coordinates so they never wrap.
    assign x_end = {1'b0, lx} + {5'b0, lw};
    assign y_end = {1'b0, ly} + {4'b0, lh};
    assign wall  = (x_end > 11'(SCR_W)) || (y_end > 10'(SCR_H));
    assign last  = (idx == 4'(NUM_OBS - 1));

    // Half-open overlap; an empty box never overlaps even when strictly inside a rectangle.
    assign ov = (lw != 6'd0) && (lh != 6'd0) &&
                (lx < obs_right[idx]) && (x_end > {1'b0, obs_left[idx]}) &&
                (ly < obs_bottom[idx]) && (y_end > {1'b0, obs_top[idx]});

    always_ff @(posedge Clk) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (req) state_nx = BOUNDS;
            BOUNDS: state_nx = wall ? DONE : SCAN;
`ifdef COLLISION_EARLY_EXIT_EN
            SCAN:   if (ov || last) state_nx = DONE;
`else
            SCAN:   if (last) state_nx = DONE;
`endif
            DONE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == BOUNDS) || (state == SCAN);
        done = (state == DONE);
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            lx        <= '0;
            ly        <= '0;
            lw        <= '0;
            lh        <= '0;
            idx       <= '0;
            hit_f     <= 1'b0;
            hit_idx_f <= '0;
            hit       <= 1'b0;
            hit_index <= '0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    lx        <= qx;
                    ly        <= qy;
                    lw        <= qw;
                    lh        <= qh;
                    idx       <= '0;
                    hit_f     <= 1'b0;
                    hit_idx_f <= '0;
                end
                BOUNDS: if (wall) begin
                    hit       <= 1'b1;
                    hit_index <= 4'(NUM_OBS);
                end
                SCAN: begin
                    if (ov && !hit_f) begin
                        hit_f     <= 1'b1;
                        hit_idx_f <= idx;
                    end
                    if (!last) idx <= idx + 4'd1;
                    // Publish the result on the edge that enters DONE, folding in this cycle's test.
                    if (state_nx == DONE) begin
                        hit       <= hit_f | ov;
                        hit_index <= hit_f ? hit_idx_f : (ov ? idx : 4'd0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_obstacle_collision_checker.sv
// Bench for obstacle_collision_checker: cycle-level reference model plus directed and random queries.
module tb_obstacle_collision_checker;

    localparam int NO = 12;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    logic req = 1'b0;
    logic [9:0] qx = '0;
    logic [8:0] qy = '0;
    logic [5:0] qw = '0, qh = '0;
    logic [NO-1:0][9:0] obs_left, obs_right;
    logic [NO-1:0][8:0] obs_top, obs_bottom;
    logic busy, done, hit;
    logic [3:0] hit_index;

    obstacle_collision_checker #(.NUM_OBS(NO), .SCR_W(640), .SCR_H(480)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .req(req),
        .qx(qx), .qy(qy), .qw(qw), .qh(qh),
        .obs_left(obs_left), .obs_right(obs_right),
        .obs_top(obs_top), .obs_bottom(obs_bottom),
        .busy(busy), .done(done), .hit(hit), .hit_index(hit_index)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad = 0;
    bit armed = 0;

`ifdef COLLISION_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Result packed as hit + 2*index + 256*latency (cycles from the req cycle to the done cycle).
    function automatic int ref_model(input int x, input int y, input int w, input int h);
        if (x + w > 640 || y + h > 480) return 1 + 2 * NO + 256 * 2;
        for (int k = 0; k < NO; k++) begin
            if (w > 0 && h > 0 &&
                x < int'(obs_right[k]) && x + w > int'(obs_left[k]) &&
                y < int'(obs_bottom[k]) && y + h > int'(obs_top[k]))
                return 1 + 2 * k + 256 * (EARLY ? k + 3 : NO + 2);
        end
        return 256 * (NO + 2);
    endfunction

    int cnt = -1;
    int r_res = 0;
    int m_hit = 0, m_idx = 0;

    always @(posedge Clk) begin
        if (!Reset_n) begin
            cnt <= -1;
            m_hit <= 0;
            m_idx <= 0;
        end else if (cnt < 0) begin
            if (req) begin
                r_res <= ref_model(int'(qx), int'(qy), int'(qw), int'(qh));
                cnt <= 1;
            end
        end else if (cnt == r_res / 256) begin
            cnt <= -1;
        end else begin
            cnt <= cnt + 1;
            if (cnt + 1 == r_res / 256) begin
                m_hit <= r_res % 2;
                m_idx <= (r_res / 2) % 16;
            end
        end
    end

    always @(negedge Clk) begin
        if (armed) begin
            chk("busy", int'(busy), int'(cnt >= 1 && cnt < r_res / 256));
            chk("done", int'(done), int'(cnt >= 1 && cnt == r_res / 256));
            chk("hit", int'(hit), m_hit);
            chk("hit_index", int'(hit_index), m_idx);
        end
    end

    task automatic set_rect(input int k, input int l, input int r, input int t, input int b);
        obs_left[k] = 10'(l);
        obs_right[k] = 10'(r);
        obs_top[k] = 9'(t);
        obs_bottom[k] = 9'(b);
    endtask

    task automatic set_map(input int m);
        for (int k = 2; k < NO; k++) set_rect(k, 150 + 36 * (k - 2), 170 + 36 * (k - 2), 300, 330);
        if (m == 0) begin
            set_rect(0, 40, 80, 40, 80);
            set_rect(1, 500, 540, 100, 140);
        end else begin
            set_rect(0, 90, 110, 220, 240);
            set_rect(1, 105, 130, 235, 260);
        end
    endtask

    task automatic rand_map();
        for (int k = 0; k < NO; k++) begin
            int l, t;
            l = int'($urandom_range(0, 600));
            t = int'($urandom_range(0, 450));
            set_rect(k, l, l + int'($urandom_range(1, 60)), t, t + int'($urandom_range(1, 40)));
        end
    endtask

    task automatic run_query(input int x, input int y, input int w, input int h,
                             output int lat, output int nbusy);
        @(negedge Clk);
        qx = 10'(x); qy = 9'(y); qw = 6'(w); qh = 6'(h);
        req = 1'b1;
        @(negedge Clk);
        req = 1'b0;
        lat = 1;
        nbusy = 0;
        while (!done && lat < 40) begin
            if (busy) nbusy++;
            @(negedge Clk);
            lat++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int lat, nb, ndone;
        set_map(0);
        repeat (3) @(posedge Clk);
        armed = 1;
        @(negedge Clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_hit", int'(hit), 0);
        chk("rst_idx", int'(hit_index), 0);
        Reset_n = 1'b1;

        run_query(60, 60, 16, 16, lat, nb);
        chk("q1_lat", lat, 14); chk("q1_hit", int'(hit), 1);
        chk("q1_idx", int'(hit_index), 0); chk("q1_busy", nb, 13);
        run_query(10, 10, 16, 16, lat, nb);
        chk("q2_lat", lat, 14); chk("q2_hit", int'(hit), 0); chk("q2_idx", int'(hit_index), 0);
        run_query(630, 10, 16, 16, lat, nb);
        chk("q3_lat", lat, 2); chk("q3_hit", int'(hit), 1); chk("q3_idx", int'(hit_index), 12);
        run_query(80, 50, 10, 10, lat, nb);
        chk("q4_touch_hit", int'(hit), 0);
        run_query(60, 60, 0, 16, lat, nb);
        chk("q_zero_hit", int'(hit), 0); chk("q_zero_lat", lat, 14);
        run_query(624, 464, 16, 16, lat, nb);
        chk("q_edge_lat", lat, 14); chk("q_edge_hit", int'(hit), 0);
        run_query(625, 464, 16, 16, lat, nb);
        chk("q_wall_idx", int'(hit_index), 12);
        set_map(1);
        run_query(100, 230, 20, 20, lat, nb);
        chk("q5_hit", int'(hit), 1); chk("q5_idx", int'(hit_index), 0);
        chk("q5_lat", lat, EARLY ? 3 : 14);
        set_map(0);

        // Reset while scanning obstacle 5.
        run_query(60, 60, 16, 16, lat, nb);
        @(negedge Clk);
        qx = 10'd10; qy = 9'd10; qw = 6'd16; qh = 6'd16; req = 1'b1;
        @(negedge Clk);
        req = 1'b0;
        repeat (6) @(negedge Clk);
        Reset_n = 1'b0;
        @(negedge Clk);
        chk("mid_rst_busy", int'(busy), 0); chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_hit", int'(hit), 0); chk("mid_rst_idx", int'(hit_index), 0);
        Reset_n = 1'b1;
        ndone = 0;
        repeat (30) begin @(negedge Clk); if (done) ndone++; end
        chk("mid_rst_no_done", ndone, 0);
        run_query(60, 60, 16, 16, lat, nb);
        chk("post_rst_lat", lat, 14); chk("post_rst_hit", int'(hit), 1);

        // A second req while busy must not be queued.
        @(negedge Clk);
        qx = 10'd10; qy = 9'd10; req = 1'b1;
        @(negedge Clk);
        req = 1'b0;
        ndone = 0;
        for (int c = 1; c < 40; c++) begin
            if (c == 5) req = 1'b1;
            if (c == 6) req = 1'b0;
            if (done) ndone++;
            @(negedge Clk);
        end
        chk("busy_req_ignored", ndone, 1);

        for (int it = 0; it < 200; it++) begin
            int k, x, y;
            if (it % 20 == 0) rand_map();
            k = int'($urandom_range(0, NO - 1));
            if ($urandom_range(0, 1) == 1) begin
                x = int'(obs_left[k]) - 30 + int'($urandom_range(0, 40));
                y = int'(obs_top[k]) - 30 + int'($urandom_range(0, 40));
                if (x < 0) x = 0;
                if (y < 0) y = 0;
                if (x > 639) x = 639;
                if (y > 479) y = 479;
            end else begin
                x = int'($urandom_range(0, 639));
                y = int'($urandom_range(0, 479));
            end
            run_query(x, y, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), lat, nb);
            repeat ($urandom_range(0, 2)) @(negedge Clk);
        end

        repeat (2) @(negedge Clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
